// File: rtl/tcam_pkg.sv
// Shared definitions for the priority TCAM array.
// Op encodings and flush FSM state type.
package tcam_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } tcam_st_e;

endpackage

// File: rtl/tcam_prio_arr_enc.sv
// Lowest-index priority encoder with hit and popcount.
// Purely combinational; the caller registers the outputs.
module tcam_prio_enc #(
  parameter int WORD_NUM = 8,
  localparam int ADDR_W = $clog2(WORD_NUM),
  localparam int CNT_W  = $clog2(WORD_NUM + 1)
) (
  input  logic [WORD_NUM-1:0] vec_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                hit_o,
  output logic [CNT_W-1:0]    cnt_o
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    addr_o = '0;
    cnt_o  = '0;
    for (int i = WORD_NUM - 1; i >= 0; i--) begin
      if (vec_i[i]) addr_o = ADDR_W'(i);
    end
    for (int i = 0; i < WORD_NUM; i++) begin
      cnt_o = cnt_o + CNT_W'(vec_i[i]);
    end
  end

  assign hit_o = |vec_i;

endmodule

// File: rtl/tcam_prio_arr.sv
// Ternary CAM array with 2-stage search pipeline,
// occupancy tracking and multi-cycle flush.
module tcam_prio_arr
  import tcam_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_NUM   = 8,
  localparam int ADDR_W = $clog2(WORD_NUM),
  localparam int CNT_W  = $clog2(WORD_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            op,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic [WORD_WIDTH-1:0] mask_in,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [ADDR_W-1:0]     rsp_addr,
  output logic                  rsp_multi,
  output logic [CNT_W-1:0]      rsp_count,
  output logic [WORD_NUM-1:0]   rsp_match_vec,
  output logic [CNT_W-1:0]      used_cnt,
  output logic                  full
);

  logic [WORD_WIDTH-1:0] word_q [WORD_NUM];
  logic [WORD_WIDTH-1:0] mask_q [WORD_NUM];
  logic [WORD_NUM-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]      used_q, used_d;

  tcam_st_e              st_q, st_d;
  logic [ADDR_W-1:0]     fcnt_q, fcnt_d;
  logic                  init_q;

  logic [WORD_NUM-1:0]   match_d;
  logic                  s1_vld_q;
  logic [WORD_NUM-1:0]   s1_vec_q;

  logic [ADDR_W-1:0]     enc_addr;
  logic                  enc_hit;
  logic [CNT_W-1:0]      enc_cnt;

  logic acc, wr_en, sr_en, cl_en, fl_start, fl_en;

  assign req_ready = init_q && (st_q == ST_IDLE);
  assign acc       = req_valid && req_ready;
  assign wr_en     = acc && (op == OP_WRITE);
  assign sr_en     = acc && (op == OP_SEARCH);
  assign cl_en     = acc && (op == OP_CLEAR);
  assign fl_start  = acc && (op == OP_FLUSH);
  assign fl_en     = (st_q == ST_FLUSH);

  always_comb begin
    for (int i = 0; i < WORD_NUM; i++) begin
      match_d[i] = valid_q[i] &&
        (((word_in ^ word_q[i]) & mask_q[i] & mask_in) == '0);
    end
  end

  always_comb begin
    st_d   = st_q;
    fcnt_d = fcnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (fl_start) begin
          st_d   = ST_FLUSH;
          fcnt_d = '0;
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == ADDR_W'(WORD_NUM - 1)) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Only one of write/clear/flush-step can be active in a cycle.
  always_comb begin
    valid_d = valid_q;
    used_d  = used_q;
    if (wr_en) begin
      valid_d[addr_in] = 1'b1;
      if (!valid_q[addr_in]) used_d = used_q + 1'b1;
    end
    if (cl_en) begin
      valid_d[addr_in] = 1'b0;
      if (valid_q[addr_in]) used_d = used_q - 1'b1;
    end
    if (fl_en) begin
      valid_d[fcnt_q] = 1'b0;
      if (valid_q[fcnt_q]) used_d = used_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORD_NUM; i++) begin
        word_q[i] <= '0;
        mask_q[i] <= '0;
      end
      valid_q <= '0;
      used_q  <= '0;
      st_q    <= ST_IDLE;
      fcnt_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        word_q[addr_in] <= word_in;
        mask_q[addr_in] <= mask_in;
      end
      valid_q <= valid_d;
      used_q  <= used_d;
      st_q    <= st_d;
      fcnt_q  <= fcnt_d;
      init_q  <= 1'b1;
    end
  end

  tcam_prio_enc #(
    .WORD_NUM(WORD_NUM)
  ) u_enc (
    .vec_i (s1_vec_q),
    .addr_o(enc_addr),
    .hit_o (enc_hit),
    .cnt_o (enc_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q      <= 1'b0;
      s1_vec_q      <= '0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_addr      <= '0;
      rsp_multi     <= 1'b0;
      rsp_count     <= '0;
      rsp_match_vec <= '0;
    end else begin
      s1_vld_q  <= sr_en;
      rsp_valid <= s1_vld_q;
      if (sr_en) s1_vec_q <= match_d;
      if (s1_vld_q) begin
        rsp_hit       <= enc_hit;
        rsp_addr      <= enc_addr;
        rsp_multi     <= (enc_cnt > CNT_W'(1));
        rsp_count     <= enc_cnt;
        rsp_match_vec <= s1_vec_q;
      end
    end
  end

  assign used_cnt = used_q;
  assign full     = (used_q == CNT_W'(WORD_NUM));

endmodule

// File: doc/tcam_prio_arr.md
Name: tcam_prio_arr

Overview:
Parametrised ternary CAM array; successor to the basic mem_arr.
- Each entry stores a word, a per-entry care mask and a valid bit.
- Adds a request handshake, a 2-stage registered search pipeline with lowest-index priority encoding and multi-hit/popcount reporting, an occupancy counter, and a multi-cycle flush-all operation.
- Sits between the lookup controller and result consumers in the TCAM datapath.

Parameters:
WORD_WIDTH, 8, bits per stored word, key and mask
WORD_NUM, 8, number of entries (>=2)
ADDR_W, $clog2(WORD_NUM), entry address width (derived, not overridden)
CNT_W, $clog2(WORD_NUM+1), width of the count and occupancy outputs (derived)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  array can accept a request this cycle
op  in  2  00 write, 01 search, 10 clear entry, 11 flush all
addr_in  in  ADDR_W  entry address for write/clear
word_in  in  WORD_WIDTH  data for write; key for search
mask_in  in  WORD_WIDTH  entry care-mask for write (1 = compare); search mask for search
rsp_valid  out  1  one-cycle pulse: search result valid
rsp_hit  out  1  at least one entry matched
rsp_addr  out  ADDR_W  lowest matching index (0 if no hit)
rsp_multi  out  1  more than one entry matched
rsp_count  out  CNT_W  number of matching entries
rsp_match_vec  out  WORD_NUM  raw match vector, bit i = entry i
used_cnt  out  CNT_W  number of valid entries
full  out  1  used_cnt == WORD_NUM

Behaviour:
- Reset (async, rst_n=0):
  - All entries: valid=0, word=0, mask=0.
  - FSM goes to IDLE; pipeline valid bits are cleared.
  - All rsp_* outputs are 0; used_cnt=0; full=0.
  - req_ready=1 from the first clock edge after reset release.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. One operation per cycle.
- Write: at the accept edge, entry[addr_in] takes word_in and mask_in, and valid becomes 1. used_cnt increments only if the entry was previously invalid.
- Clear: at the accept edge, entry[addr_in].valid becomes 0. used_cnt decrements only if the entry was previously valid. Clearing an invalid entry is a no-op.
- Search match rule: entry i matches iff valid[i] && (((word_in ^ word[i]) & mask[i] & mask_in) == 0).
  - Stage 1: the match vector is computed combinationally against the array state before the accept edge, and registered at the accept edge E0.
  - Stage 2: priority encoder and popcount results are registered at E1.
  - rsp_valid is high for exactly the cycle after E1. Latency is 2 edges.
- Back-to-back searches give one rsp_valid per cycle, in order. There is no response backpressure.
- A write or clear accepted at E0 is visible to a search accepted at E1 or later. It is never visible to a search accepted at E0 or earlier.
- Priority: lowest index wins. rsp_multi = (rsp_count > 1). rsp_hit = (rsp_count != 0).
- rsp_* fields hold their last values when rsp_valid=0.
- Flush FSM, states IDLE and FLUSH:
  - op=11 accepted in IDLE: go to FLUSH, load a counter with 0, deassert req_ready starting the next cycle.
  - In FLUSH, one entry per cycle: valid[cnt] becomes 0, used_cnt decrements if that entry was valid, cnt increments.
  - After entry WORD_NUM-1 is cleared, return to IDLE. req_ready is 1 in the following cycle.
  - Flush lasts WORD_NUM cycles. Searches already in the pipeline complete with their captured vector.
- req_ready is 0 throughout FLUSH. req_valid during FLUSH is ignored, not queued.
- Reset mid-flush aborts the flush; everything returns to reset values.
- full is combinational from used_cnt; used_cnt never exceeds WORD_NUM and never underflows.

Decomposition:
- Package tcam_pkg holds:
  - op encodings OP_WRITE=2'b00, OP_SEARCH=2'b01, OP_CLEAR=2'b10, OP_FLUSH=2'b11;
  - FSM state typedef {ST_IDLE, ST_FLUSH}.
- Sub-module tcam_prio_enc (parameter WORD_NUM): combinational match vector in; lowest-index address, hit, popcount out. Instantiated once, with its outputs registered in stage 2.

Test Plan:
1. Reset and idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately. After release, req_ready=1, used_cnt=0, full=0.
2. Exact writes and search:
   - Stimulus: write addr 7..1 with words 1..7, mask 0xFF. Then search key 3, mask 0xFF.
   - Response: used_cnt=7. Two edges after accept: rsp_valid=1, hit=1, addr=5, count=1, match_vec=0x20. Search key 0 -> hit=0, count=0.
3. Clear: clear addr 1, then search key 7 -> hit=0, used_cnt=6. Clearing addr 1 again -> used_cnt stays 6.
4. Multi-match:
   - Stimulus: write addr 7 word 0xFC mask 0xFC (used_cnt unchanged at 6). Write addr 6 word 0xFE mask 0xFE.
   - Search 0xFE, mask 0xFF -> match_vec=0xC0, addr=6, multi=1, count=2.
   - Search 0xFD -> match_vec=0x80, addr=7, multi=0.
5. Pipeline ordering: search issued every cycle while a write to addr 0 (word 0xAA) is accepted between two of them. Each search result reflects only writes accepted strictly before it; rsp_valid arrives every cycle, in order.
6. Flush:
   - op=11 -> req_ready=0 for exactly 8 cycles, used_cnt counts down to 0, then req_ready=1. A following search 0xFE -> hit=0.
   - Repeat the flush with rst_n asserted in flush cycle 3 -> req_ready=1 and used_cnt=0 after reset release.
